// File: rtl/pll_supervisor.sv
// Lock supervisor for an ECP5 EHXPLLL. It filters LOCK, retries the PLL when lock times out,
// releases the channel resets in a staggered order, and performs handshaked dynamic phase steps.
module pll_supervisor #(
    parameter int NUM_CH       = 3,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_FILT    = 1024,
    parameter int STAGGER      = 8,
    parameter int STEP_GAP     = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              pll_lock_in,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              locked,
    output logic [7:0]        relock_cnt,
    input  logic              ps_valid,
    output logic              ps_ready,
    input  logic [1:0]        ps_ch,
    input  logic              ps_dir,
    input  logic [3:0]        ps_count,
    output logic              ps_done,
    output logic              ps_err,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic [2:0]        dbg_state_o
);

    // One shared counter serves every timed state, so it is sized for the sum of all limits.
    localparam int CW = $clog2(RST_HOLD + LOCK_TIMEOUT + LOCK_FILT + NUM_CH * STAGGER + STEP_GAP + 2);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_STEP_SETUP,
        S_STEP_PULSE,
        S_STEP_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [3:0]        rem_q, rem_d;
    logic [7:0]        relock_q, relock_d;
    logic              lock_meta_q, lock_sync_q;
    logic              pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
    logic              locked_q, locked_d;
    logic              ps_ready_q, ps_ready_d;
    logic              ps_done_q, ps_done_d;
    logic              ps_err_q, ps_err_d;
    logic [1:0]        phasesel_q, phasesel_d;
    logic              phasedir_q, phasedir_d;
    logic              phasestep_q, phasestep_d;
    logic              lock_lost, accept, bad_ch;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_in;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Handshake: a request transfers on a rising CLK edge where ps_valid && ps_ready are both
    // high; ps_ready is registered and only high while idle in RUN, so no request is ever queued.
    assign accept = ps_valid && ps_ready_q;
    assign bad_ch = ({30'd0, ps_ch} >= 32'(NUM_CH));
    assign lock_lost = !lock_sync_q && (state_q inside {S_RELEASE, S_RUN, S_STEP_SETUP,
                                                       S_STEP_PULSE, S_STEP_GAP});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + CW'(1);
        rem_d      = rem_q;
        relock_d   = relock_q;
        ch_rst_n_d = ch_rst_n_q;
        ps_done_d  = 1'b0;
        ps_err_d   = 1'b0;
        phasesel_d = phasesel_q;
        phasedir_d = phasedir_q;

        case (state_q)
            S_RESET_PLL: begin
                cnt_d = cnt_inc;
                if (cnt_q == CW'(RST_HOLD - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_inc;
                if (lock_sync_q) begin
                    state_d = S_FILTER;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end
            end
            S_FILTER: begin
                cnt_d = cnt_inc;
                if (!lock_sync_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_FILT)) begin
                    state_d       = (NUM_CH == 1) ? S_RUN : S_RELEASE;
                    cnt_d         = '0;
                    ch_rst_n_d[0] = 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_inc;
                for (int i = 1; i < NUM_CH; i++) begin
                    if (cnt_inc == CW'(i * STAGGER)) ch_rst_n_d[i] = 1'b1;
                end
                if (cnt_inc == CW'((NUM_CH - 1) * STAGGER)) state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    if (ps_count == 4'd0 || bad_ch) begin
                        ps_done_d = 1'b1;
                        ps_err_d  = bad_ch;
                    end else begin
                        state_d    = S_STEP_SETUP;
                        rem_d      = ps_count;
                        phasesel_d = ps_ch;
                        phasedir_d = ps_dir;
                    end
                end
            end
            S_STEP_SETUP: state_d = S_STEP_PULSE;
            S_STEP_PULSE: begin
                cnt_d = '0;
                if (rem_q == 4'd1 && STEP_GAP <= 1) begin
                    state_d   = S_RUN;
                    ps_done_d = 1'b1;
                end else begin
                    state_d = S_STEP_GAP;
                end
            end
            S_STEP_GAP: begin
                cnt_d = cnt_inc;
                // The completion pulse coincides with the last gap cycle, so leave one early.
                if (rem_q == 4'd1 && cnt_q == CW'(STEP_GAP - 2)) begin
                    state_d   = S_RUN;
                    ps_done_d = 1'b1;
                end else if (cnt_q == CW'(STEP_GAP - 1)) begin
                    state_d = S_STEP_PULSE;
                    rem_d   = rem_q - 4'd1;
                end
            end
            default: state_d = S_RESET_PLL;
        endcase

        if (lock_lost) begin
            state_d   = S_RESET_PLL;
            cnt_d     = '0;
            ps_done_d = 1'b0;
            ps_err_d  = 1'b0;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end

        pll_rst_d = (state_d == S_RESET_PLL);
        locked_d  = state_d inside {S_RELEASE, S_RUN, S_STEP_SETUP, S_STEP_PULSE, S_STEP_GAP};
        if (!locked_d) ch_rst_n_d = '0;
        phasestep_d = (state_d == S_STEP_PULSE);
        ps_ready_d  = (state_d == S_RUN) && !ps_done_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            rem_q       <= '0;
            relock_q    <= '0;
            pll_rst_q   <= 1'b1;
            ch_rst_n_q  <= '0;
            locked_q    <= 1'b0;
            ps_ready_q  <= 1'b0;
            ps_done_q   <= 1'b0;
            ps_err_q    <= 1'b0;
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            relock_q    <= relock_d;
            pll_rst_q   <= pll_rst_d;
            ch_rst_n_q  <= ch_rst_n_d;
            locked_q    <= locked_d;
            ps_ready_q  <= ps_ready_d;
            ps_done_q   <= ps_done_d;
            ps_err_q    <= ps_err_d;
            phasesel_q  <= phasesel_d;
            phasedir_q  <= phasedir_d;
            phasestep_q <= phasestep_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign ch_rst_n    = ch_rst_n_q;
    assign locked      = locked_q;
    assign relock_cnt  = relock_q;
    assign ps_ready    = ps_ready_q;
    assign ps_done     = ps_done_q;
    assign ps_err      = ps_err_q;
    assign phasesel    = phasesel_q;
    assign phasedir    = phasedir_q;
    assign phasestep   = phasestep_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Lock supervisor and dynamic-phase controller for an ECP5 EHXPLLL. It runs on the PLL reference clock and drives the PLL RST input. It filters the raw LOCK signal, retries the PLL on lock timeout, and releases per-output-domain resets in a staggered order. It also performs handshaked dynamic phase steps on a selected output, using the PHASESEL/PHASEDIR/PHASESTEP pins the static wrapper ties off. It sits between the board clock input and the per-domain reset synchronisers in the top level.

## Interface
Parameters:
- NUM_CH, 3: number of PLL output channels supervised (1..4)
- RST_HOLD, 16: cycles pll_rst is held high per reset attempt
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry
- LOCK_FILT, 1024: consecutive synchronised-lock cycles required before lock is declared
- STAGGER, 8: cycles between successive channel reset releases
- STEP_GAP, 4: low cycles after each phasestep pulse

Ports:
- CLK  in  1  PLL reference clock (25 MHz); the only clock
- RST_N  in  1  reset; asynchronous assert, active-low
- pll_lock_in  in  1  raw EHXPLLL LOCK; asynchronous, double-flop synchronised internally
- pll_rst  out  1  to EHXPLLL RST
- ch_rst_n  out  NUM_CH  per-channel reset release, active-low; consumers resynchronise it
- locked  out  1  filtered lock status
- relock_cnt  out  8  saturating count of lock losses after lock was declared
- ps_valid  in  1  phase-step request
- ps_ready  out  1  request accepted when ps_valid && ps_ready
- ps_ch  in  2  channel to step; maps to PHASESEL
- ps_dir  in  1  step direction; maps to PHASEDIR
- ps_count  in  4  number of steps (0..15)
- ps_done  out  1  one-cycle completion pulse
- ps_err  out  1  one-cycle pulse with ps_done when ps_ch >= NUM_CH
- phasesel  out  2  to EHXPLLL PHASESEL[1:0]
- phasedir  out  1  to EHXPLLL PHASEDIR
- phasestep  out  1  to EHXPLLL PHASESTEP

## Operation
- States: RESET_PLL, WAIT_LOCK, FILTER, RELEASE, RUN, STEP_SETUP, STEP_PULSE, STEP_GAP.
- RESET_PLL: pll_rst=1, all ch_rst_n=0, locked=0. After RST_HOLD cycles go to WAIT_LOCK with pll_rst=0.
- WAIT_LOCK: if lock_sync=1, go to FILTER. If the timeout counter reaches LOCK_TIMEOUT, go to RESET_PLL; relock_cnt is not incremented.
- FILTER: counts consecutive lock_sync=1 cycles. A single 0 returns to WAIT_LOCK, restarting both the filter and timeout counters. At LOCK_FILT cycles go to RELEASE.
- RELEASE: locked=1 on entry. ch_rst_n[0] goes high on entry and ch_rst_n[i] goes high i*STAGGER cycles after entry. When the last channel is released, go to RUN.
- Loss of lock (lock_sync=0) in RELEASE, RUN or any STEP state:
  - next cycle: locked=0, all ch_rst_n=0, phasestep=0
  - relock_cnt increments, saturating at 255
  - state goes to RESET_PLL
  - an in-flight step is abandoned and ps_done is not pulsed
- RUN: ps_ready=1, which is the only state with ps_ready high.
- On accept:
  - latch ps_ch, ps_dir and ps_count
  - ps_count=0, or ps_ch >= NUM_CH: pulse ps_done the next cycle (ps_err=1 for a bad channel), stay in RUN, no phasestep
  - otherwise go to STEP_SETUP
- STEP_SETUP: drive phasesel and phasedir for 1 cycle, with phasestep=0.
- STEP_PULSE: phasestep=1 for 1 cycle. phasesel and phasedir stay stable for the whole step sequence.
- STEP_GAP: phasestep=0 for STEP_GAP cycles, then decrement the remaining count. If nonzero, go to STEP_PULSE. If zero, pulse ps_done and go to RUN.
- Phase stepping never touches ch_rst_n.

## Timing
- While RST_N is low, all outputs are at reset values: pll_rst=1, ch_rst_n=0, locked=0, relock_cnt=0, ps_ready=0, ps_done=0, ps_err=0, phasesel=0, phasedir=0, phasestep=0. State is RESET_PLL.
- The first cycle after RST_N deassertion is the first RST_HOLD cycle.
- The lock synchroniser adds 2 cycles of latency. Minimum time from pll_rst falling to locked=1 is 2+LOCK_FILT cycles when LOCK is already high.
- The first phasestep pulse is 2 cycles after accept. Steps recur every 1+STEP_GAP cycles. ps_done occurs 1+N*(1+STEP_GAP) cycles after accept.
- ps_ready drops the cycle after accept and is high again the cycle after ps_done.
- All outputs are registered; none are combinational from inputs.

## Test plan
- Reset, LOCK held 1 with defaults -> pll_rst high for 16 cycles; locked=1 at cycle 16+2+1024; ch_rst_n releases 0, 8, 16 cycles later; ps_ready=1 afterward.
- LOCK never asserts, LOCK_TIMEOUT=100 -> pll_rst re-pulses every 116 cycles; relock_cnt stays 0.
- LOCK glitches low once mid-FILTER -> filter restarts; locked delayed by the glitch position plus LOCK_FILT; relock_cnt=0.
- In RUN, request ch=1, dir=1, count=3 -> phasesel=1, phasedir=1; phasestep high on cycles 2, 7, 12 after accept; ps_done on cycle 16.
- Request with ch=3 (NUM_CH=3), and separately count=0 -> ps_done next cycle (ps_err=1 for the bad channel only); phasestep never pulses.
- LOCK drops during the second step -> next cycle locked=0, ch_rst_n=0, phasestep=0; relock_cnt=1; no ps_done; full relock sequence follows.
